breath_pwm_multi: RTL
=====================

# breath_pwm_multi

Multi-channel, parameterised breathing-light PWM generator: a prescaled PWM frame counter, a duty ramp state machine with hold plateaus, and per-channel gating with breathe, solid, blink and anti-phase modes. It drives the indicator LEDs of the alarm design, one `pwm` bit per LED, from a single shared ramp so all channels stay phase-locked. Duty changes only on PWM frame boundaries, so no frame is ever truncated or glitched.

## Interface
- `CLK_DIV`, 50: clocks per PWM tick, ≥1.
- `PWM_BITS`, 8: duty resolution. A frame is 2^PWM_BITS ticks.
- `FRAMES_PER_STEP`, 4: PWM frames per duty step, ≥1.
- `HOLD_STEPS`, 16: steps spent at the top plateau and at the bottom plateau. 0 means no plateau.
- `CHANNELS`, 4: number of PWM outputs, ≥1.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run enable. Low forces idle and all outputs low.
- `mode` input 2: 0 breathe, 1 solid, 2 blink, 3 anti-phase breathe.
- `ch_mask` input CHANNELS: per-channel enable. A 0 bit forces that `pwm` bit low.
- `pwm` output CHANNELS: registered PWM outputs.
- `duty` output PWM_BITS: current ramp duty, pre-gamma.
- `cycle_done` output 1: one-clock pulse at the end of each full breath cycle.

## Operation
- Reset values: all counters 0, state IDLE, `duty`=0, `pwm`=0, `cycle_done`=0, mode register=0.
- Prescaler `div_cnt` counts 0..CLK_DIV-1. `tick` is asserted when `div_cnt`==CLK_DIV-1.
- `pwm_cnt` (PWM_BITS wide) advances on `tick` and wraps naturally. `frame_end` = `tick` && `pwm_cnt`==all-ones.
- Step counter counts 0..FRAMES_PER_STEP-1 on `frame_end`. `step` = `frame_end` && step counter at max.
- FSM states and transitions:
  - IDLE: while `en`=0. On `en`=1, go to RISE with `duty`=0 and all counters cleared.
  - RISE: `duty`+1 per `step`. At `duty`=max, go to HOLD_HI, or to FALL if HOLD_STEPS=0.
  - HOLD_HI: lasts HOLD_STEPS `step`s, then go to FALL.
  - FALL: `duty`-1 per `step`. At `duty`=0, go to HOLD_LO, or to RISE if HOLD_STEPS=0.
  - HOLD_LO: lasts HOLD_STEPS `step`s, then go to RISE.
- `duty` never wraps: it saturates at 0 and at max.
- `cycle_done` pulses on the clock where the FSM enters RISE from HOLD_LO or FALL. It does not pulse on entry from IDLE.
- `mode` is sampled into the mode register only on `frame_end`. The output path uses only the registered mode.
- `eff` is `duty` after optional gamma (see Configuration).
- Per-channel output `pwm[i]` = `en` && `ch_mask[i]` && X, where X is:
  - mode 0: `pwm_cnt` < `eff`.
  - mode 1: 1.
  - mode 2: 1 in RISE and HOLD_HI; 0 in FALL and HOLD_LO.
  - mode 3: as mode 0 for even i; `pwm_cnt` < (max−`eff`) for odd i.
- Duty 0 gives a constant-low frame. Duty max gives high for 2^PWM_BITS−1 of 2^PWM_BITS ticks.
- `en` falling mid-operation: next clock goes to IDLE, clears counters and `duty`, and drives `pwm`=0. Re-enable restarts from RISE with `duty`=0.
- `ch_mask` takes effect on the next clock, unsynchronised to frames.

## Timing
- `pwm` is registered: it reflects the current-cycle `pwm_cnt`, `eff` and mode register one clock later.
- `duty` and state update on the clock of `step`. The new duty is first visible in the frame starting at `pwm_cnt`=0.
- Full cycle length with HOLD_STEPS>0: (2·(2^PWM_BITS−1) + 2·HOLD_STEPS) · FRAMES_PER_STEP · 2^PWM_BITS · CLK_DIV clocks.
- Reset assertion is asynchronous and takes effect immediately. Release is synchronous to `clk`.

## Configuration
- `BREATH_GAMMA_EN` defined: `eff` = (`duty`·`duty`) >> PWM_BITS. The product is 2·PWM_BITS wide with no overflow, giving a perceptually linear fade.
- `BREATH_GAMMA_EN` undefined: `eff` = `duty`. No multiplier is instantiated.

## Test plan
All scenarios use CLK_DIV=2, PWM_BITS=3, FRAMES_PER_STEP=1, HOLD_STEPS=2, CHANNELS=2, with gamma off unless stated. A frame is 16 clocks.
- Reset, then `en`=1, `ch_mask`=2'b11, mode 0 → `duty` reads 0,1..7,7,7,6..0,0,0. The first `cycle_done` arrives 288 clocks after RISE entry, then every 288 clocks.
- Mode 0, `duty`=3 → each `pwm` bit is high for exactly 6 of 16 clocks per frame. `duty`=0 → constant low. `duty`=7 → high 14 of 16 clocks.
- Mode 3, `duty`=2 → `pwm[0]` high 4 of 16 clocks, `pwm[1]` high 10 of 16 clocks, every frame.
- `mode` changed from 0 to 1 mid-frame → `pwm` is unchanged until the next `frame_end`, then constant 2'b11.
- Drop `en` during FALL at `duty`=4 → next clock `pwm`=0 and `duty`=0. Re-enable → RISE restarts from 0 with no `cycle_done` pulse.
- `BREATH_GAMMA_EN` defined, `duty`=7 → `eff`=6: high 12 of 16 clocks. `duty`=2 → `eff`=0: constant low.

Source files
------------

// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing-light PWM: prescaled frame counter, shared duty ramp FSM
// with hold plateaus, per-channel gating. Optional gamma via `BREATH_GAMMA_EN.

module breath_pwm_lane #(
  parameter int PWM_BITS = 8,
  parameter bit ANTI     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mask,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] eff,
  input  logic                blink_on,
  output logic                pwm
);
  localparam logic [PWM_BITS-1:0] DMAX = '1;

  logic x;
  logic pwm_q;

  always_comb begin
    x = 1'b0;
    case (mode)
      2'd0:    x = (cnt < eff);
      2'd1:    x = 1'b1;
      2'd2:    x = blink_on;
      default: x = ANTI ? (cnt < (DMAX - eff)) : (cnt < eff);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= en & mask & x;
  end

  assign pwm = pwm_q;
endmodule

module breath_pwm_multi #(
  parameter int CLK_DIV         = 50,
  parameter int PWM_BITS        = 8,
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_STEPS      = 16,
  parameter int CHANNELS        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] ch_mask,
  output logic [CHANNELS-1:0] pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                cycle_done
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] DMAX      = '1;

  typedef enum logic [2:0] {S_IDLE, S_RISE, S_HOLD_HI, S_FALL, S_HOLD_LO} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [STEP_W-1:0]   step_cnt_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0]          mode_q;
  logic                done_q, done_d;
  logic                run, tick, frame_end, step;
  logic [PWM_BITS-1:0] eff;
  logic                blink_on;

  // Counters only run once the FSM has left IDLE, so RISE starts from a clean frame.
  assign run       = en && (state_q != S_IDLE);
  assign tick      = run && (div_cnt_q == DIV_LAST);
  assign frame_end = tick && (pwm_cnt_q == DMAX);
  assign step      = frame_end && (step_cnt_q == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else if (!run) begin
      div_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (frame_end) step_cnt_q <= step ? '0 : step_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      duty_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RISE;
          duty_d  = '0;
          hold_d  = '0;
        end
        S_RISE: if (step) begin
          if (duty_q != DMAX) duty_d = duty_q + 1'b1;
          if (duty_q >= DMAX - 1'b1) state_d = (HOLD_STEPS == 0) ? S_FALL : S_HOLD_HI;
        end
        S_HOLD_HI: if (step) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_FALL;
            hold_d  = '0;
          end else hold_d = hold_q + 1'b1;
        end
        S_FALL: if (step) begin
          if (duty_q != '0) duty_d = duty_q - 1'b1;
          if (duty_q <= 1) begin
            if (HOLD_STEPS == 0) begin
              state_d = S_RISE;
              done_d  = 1'b1;
            end else state_d = S_HOLD_LO;
          end
        end
        S_HOLD_LO: if (step) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_RISE;
            hold_d  = '0;
            done_d  = 1'b1;
          end else hold_d = hold_q + 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      // Mode only switches between frames so no frame is cut short.
      if (frame_end) mode_q <= mode;
    end
  end

`ifdef BREATH_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq = duty_q * duty_q;
  assign eff     = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign eff = duty_q;
`endif

  assign blink_on = (state_q == S_RISE) || (state_q == S_HOLD_HI);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    breath_pwm_lane #(
      .PWM_BITS(PWM_BITS),
      .ANTI    ((g % 2) == 1)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mask    (ch_mask[g]),
      .mode    (mode_q),
      .cnt     (pwm_cnt_q),
      .eff     (eff),
      .blink_on(blink_on),
      .pwm     (pwm[g])
    );
  end

  assign duty       = duty_q;
  assign cycle_done = done_q;
endmodule
